// File: rtl/reorder_buffer_if.sv
// Dispatcher/CDB/commit signal bundle of the reorder buffer.
// The master drives allocations, results and lookups; the slave (the buffer) answers.
interface reorder_buffer_if #(
    parameter int RoB_WIDTH = 3
);
    logic                 alloc_en;
    logic [5:0]           alloc_rd;
    logic                 alloc_is_branch;
    logic                 alloc_pred_taken;
    logic [31:0]          alloc_alt_pc;
    logic [RoB_WIDTH-1:0] alloc_index;
    logic                 full;
    logic                 empty;

    logic                 cdb_en;
    logic [RoB_WIDTH-1:0] cdb_index;
    logic [31:0]          cdb_data;
    logic                 cdb_taken;

    logic [RoB_WIDTH-1:0] query_idx1;
    logic [RoB_WIDTH-1:0] query_idx2;
    logic                 query_ready1;
    logic                 query_ready2;
    logic [31:0]          query_data1;
    logic [31:0]          query_data2;

    logic                 RoB_update_en;
    logic [5:0]           RoB_update_reg;
    logic [RoB_WIDTH-1:0] RoB_update_index;
    logic [31:0]          RoB_update_data;
    logic                 flush_signal;
    logic [31:0]          redirect_pc;

    modport master (
        output alloc_en, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_alt_pc,
        output cdb_en, cdb_index, cdb_data, cdb_taken,
        output query_idx1, query_idx2,
        input  alloc_index, full, empty,
        input  query_ready1, query_ready2, query_data1, query_data2,
        input  RoB_update_en, RoB_update_reg, RoB_update_index, RoB_update_data,
        input  flush_signal, redirect_pc
    );

    modport slave (
        input  alloc_en, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_alt_pc,
        input  cdb_en, cdb_index, cdb_data, cdb_taken,
        input  query_idx1, query_idx2,
        output alloc_index, full, empty,
        output query_ready1, query_ready2, query_data1, query_data2,
        output RoB_update_en, RoB_update_reg, RoB_update_index, RoB_update_data,
        output flush_signal, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order CDB writeback,
// in-order retirement with a global flush on a branch mispredicted at commit.
module reorder_buffer #(
    parameter int         RoB_WIDTH = 3,
    parameter logic [5:0] NON_DEP   = 6'b100000
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);
    localparam int                 RoB_SIZE = 1 << RoB_WIDTH;
    localparam logic [RoB_WIDTH:0] CNT_FULL = {1'b1, {RoB_WIDTH{1'b0}}};

    logic [RoB_SIZE-1:0]  valid;
    logic [RoB_SIZE-1:0]  ready;
    logic [RoB_WIDTH-1:0] head;
    logic [RoB_WIDTH-1:0] tail;
    logic [RoB_WIDTH:0]   count;

    logic [5:0]           ent_rd        [RoB_SIZE];
    logic                 ent_is_branch [RoB_SIZE];
    logic                 ent_pred      [RoB_SIZE];
    logic                 ent_taken     [RoB_SIZE];
    logic [31:0]          ent_alt_pc    [RoB_SIZE];
    logic [31:0]          ent_data      [RoB_SIZE];

    logic                 upd_en;
    logic [5:0]           upd_reg;
    logic [RoB_WIDTH-1:0] upd_index;
    logic [31:0]          upd_data;
    logic                 flush_q;
    logic [31:0]          redirect_q;

    logic full_c;
    logic do_alloc;
    logic do_wb;
    logic head_fire;
    logic mispredict;
    logic do_commit;

    // Full/empty come from the count alone; head == tail is ambiguous.
    assign full_c     = (count == CNT_FULL);
    assign do_alloc   = bus.alloc_en && !full_c && !flush_q;
    assign do_wb      = bus.cdb_en && valid[bus.cdb_index] && !flush_q;
    assign head_fire  = valid[head] && ready[head];
    assign mispredict = head_fire && ent_is_branch[head] && (ent_taken[head] != ent_pred[head]);
    assign do_commit  = head_fire && !mispredict;

    function automatic logic [32:0] lookup(input logic [RoB_WIDTH-1:0] idx);
        if (bus.cdb_en && bus.cdb_index == idx)
            return {1'b1, bus.cdb_data};
        if (valid[idx] && ready[idx])
            return {1'b1, ent_data[idx]};
        return '0;
    endfunction

    assign {bus.query_ready1, bus.query_data1} = lookup(bus.query_idx1);
    assign {bus.query_ready2, bus.query_data2} = lookup(bus.query_idx2);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid      <= '0;
            ready      <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            upd_en     <= 1'b0;
            upd_reg    <= '0;
            upd_index  <= '0;
            upd_data   <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else if (rdy_in) begin
            if (mispredict) begin
                valid      <= '0;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                upd_en     <= 1'b0;
                flush_q    <= 1'b1;
                redirect_q <= ent_alt_pc[head];
            end else begin
                flush_q <= 1'b0;
                upd_en  <= do_commit;
                if (do_commit) begin
                    upd_reg     <= ent_rd[head];
                    upd_index   <= head;
                    upd_data    <= ent_data[head];
                    valid[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (do_wb)
                    ready[bus.cdb_index] <= 1'b1;
                if (do_alloc) begin
                    valid[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                case ({do_alloc, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload; discarded slots are scrubbed to NON_DEP so stale entries never name a register.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (mispredict) begin
                for (int i = 0; i < RoB_SIZE; i++)
                    ent_rd[i] <= NON_DEP;
            end else if (do_alloc) begin
                ent_rd[tail]        <= bus.alloc_rd;
                ent_is_branch[tail] <= bus.alloc_is_branch;
                ent_pred[tail]      <= bus.alloc_pred_taken;
                ent_alt_pc[tail]    <= bus.alloc_alt_pc;
            end
            if (do_wb) begin
                ent_data[bus.cdb_index]  <= bus.cdb_data;
                ent_taken[bus.cdb_index] <= bus.cdb_taken;
            end
        end
    end

    assign bus.alloc_index      = tail;
    assign bus.full             = full_c;
    assign bus.empty            = (count == '0);
    assign bus.RoB_update_en    = upd_en;
    assign bus.RoB_update_reg   = upd_reg;
    assign bus.RoB_update_index = upd_index;
    assign bus.RoB_update_data  = upd_data;
    assign bus.flush_signal     = flush_q;
    assign bus.redirect_pc      = redirect_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table and sequences plus random traffic
// compared every cycle against a queue-based program-order model.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rdy = 1'b1;
    int checks = 0;
    int errors = 0;

    reorder_buffer_if #(.RoB_WIDTH(3)) bus();
    reorder_buffer #(.RoB_WIDTH(3), .NON_DEP(6'b100000)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [5:0]  rd;
        bit          br;
        bit          pred;
        bit          taken;
        bit          rdy;
        logic [31:0] alt;
        logic [31:0] data;
    } ent_t;

    // Model: in-flight instructions in program order, oldest first.
    ent_t        mq[$];
    int          m_tail;
    bit          m_flush;
    bit          m_uen;
    logic [5:0]  m_ureg;
    int          m_uidx;
    logic [31:0] m_udata;
    logic [31:0] m_redir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_tail = 0; m_flush = 0; m_uen = 0; m_ureg = '0; m_uidx = 0; m_udata = '0; m_redir = '0;
    endfunction

    function automatic void model_step();
        int n0;
        bit old_flush;
        bit commit;
        bit mis;
        ent_t h;
        ent_t e;
        if (!rdy) return;
        n0 = mq.size(); old_flush = m_flush; commit = 0; mis = 0;
        h = '{default: 0};
        if (n0 > 0 && mq[0].rdy) begin
            h = mq[0]; commit = 1; mis = h.br && (h.taken != h.pred);
        end
        if (bus.cdb_en && !old_flush)
            foreach (mq[i])
                if (mq[i].idx == int'(bus.cdb_index)) begin
                    mq[i].rdy = 1; mq[i].data = bus.cdb_data; mq[i].taken = bus.cdb_taken;
                end
        if (mis) begin
            mq.delete(); m_tail = 0; m_flush = 1; m_redir = h.alt; m_uen = 0;
        end else begin
            m_flush = 0;
            m_uen = commit;
            if (commit) begin
                void'(mq.pop_front());
                m_ureg = h.rd; m_uidx = h.idx; m_udata = h.data;
            end
            if (bus.alloc_en && n0 < 8 && !old_flush) begin
                e = '{default: 0};
                e.idx = m_tail; e.rd = bus.alloc_rd; e.br = bus.alloc_is_branch;
                e.pred = bus.alloc_pred_taken; e.alt = bus.alloc_alt_pc;
                mq.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
    endfunction

    function automatic void mquery(input logic [2:0] idx, output logic r, output logic [31:0] d);
        r = 0; d = '0;
        if (bus.cdb_en && bus.cdb_index == idx) begin
            r = 1; d = bus.cdb_data;
        end else
            foreach (mq[i])
                if (mq[i].idx == int'(idx) && mq[i].rdy) begin
                    r = 1; d = mq[i].data;
                end
    endfunction

    task automatic check_all();
        logic r;
        logic [31:0] d;
        chk("alloc_index", 32'(bus.alloc_index), 32'(m_tail));
        chk("full", 32'(bus.full), 32'(mq.size() == 8));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("update_en", 32'(bus.RoB_update_en), 32'(m_uen));
        chk("update_reg", 32'(bus.RoB_update_reg), 32'(m_ureg));
        chk("update_index", 32'(bus.RoB_update_index), 32'(m_uidx));
        chk("update_data", bus.RoB_update_data, m_udata);
        chk("flush", 32'(bus.flush_signal), 32'(m_flush));
        chk("redirect_pc", bus.redirect_pc, m_redir);
        mquery(bus.query_idx1, r, d);
        chk("query_ready1", 32'(bus.query_ready1), 32'(r));
        chk("query_data1", bus.query_data1, d);
        mquery(bus.query_idx2, r, d);
        chk("query_ready2", 32'(bus.query_ready2), 32'(r));
        chk("query_data2", bus.query_data2, d);
    endtask

    task automatic idle();
        bus.alloc_en = 0; bus.alloc_rd = '0; bus.alloc_is_branch = 0;
        bus.alloc_pred_taken = 0; bus.alloc_alt_pc = '0;
        bus.cdb_en = 0; bus.cdb_index = '0; bus.cdb_data = '0; bus.cdb_taken = 0;
        bus.query_idx1 = '0; bus.query_idx2 = '0;
    endtask

    task automatic set_alloc(input logic [5:0] rd, input bit br, input bit pred, input logic [31:0] alt);
        bus.alloc_en = 1; bus.alloc_rd = rd; bus.alloc_is_branch = br;
        bus.alloc_pred_taken = pred; bus.alloc_alt_pc = alt;
    endtask

    task automatic set_cdb(input logic [2:0] idx, input logic [31:0] data, input bit taken);
        bus.cdb_en = 1; bus.cdb_index = idx; bus.cdb_data = data; bus.cdb_taken = taken;
    endtask

    // Called at posedge+1 with inputs driven; leaves time at the next posedge+1.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_update_en", 32'(bus.RoB_update_en), 0);
        chk("rst_update_reg", 32'(bus.RoB_update_reg), 0);
        chk("rst_update_index", 32'(bus.RoB_update_index), 0);
        chk("rst_update_data", bus.RoB_update_data, 0);
        chk("rst_flush", 32'(bus.flush_signal), 0);
        chk("rst_redirect", bus.redirect_pc, 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_alloc_index", 32'(bus.alloc_index), 0);
        chk("rst_query_ready1", 32'(bus.query_ready1), 0);
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 0;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit          a_en;
        logic [5:0]  rd;
        bit          c_en;
        logic [2:0]  c_idx;
        logic [31:0] c_data;
        bit          e_uen;
        logic [5:0]  e_reg;
        logic [2:0]  e_idx;
        logic [31:0] e_data;
        bit          e_empty;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int k;
        ent_t e;
        tbl[0] = '{1, 6'd1, 0, 3'd0, 32'h00, 0, 6'd0, 3'd0, 32'h00, 0};
        tbl[1] = '{1, 6'd2, 0, 3'd0, 32'h00, 0, 6'd0, 3'd0, 32'h00, 0};
        tbl[2] = '{1, 6'd3, 0, 3'd0, 32'h00, 0, 6'd0, 3'd0, 32'h00, 0};
        tbl[3] = '{0, 6'd0, 1, 3'd2, 32'h22, 0, 6'd0, 3'd0, 32'h00, 0};
        tbl[4] = '{0, 6'd0, 1, 3'd0, 32'h00, 0, 6'd0, 3'd0, 32'h00, 0};
        tbl[5] = '{0, 6'd0, 1, 3'd1, 32'h11, 1, 6'd1, 3'd0, 32'h00, 0};
        tbl[6] = '{0, 6'd0, 0, 3'd0, 32'h00, 1, 6'd2, 3'd1, 32'h11, 0};
        tbl[7] = '{0, 6'd0, 0, 3'd0, 32'h00, 1, 6'd3, 3'd2, 32'h22, 1};
        tbl[8] = '{0, 6'd0, 0, 3'd0, 32'h00, 0, 6'd3, 3'd2, 32'h22, 1};

        idle();
        model_reset();
        do_reset();

        // In-order commit of out-of-order results.
        for (int i = 0; i < 9; i++) begin
            idle();
            if (tbl[i].a_en) set_alloc(tbl[i].rd, 0, 0, 32'h0);
            if (tbl[i].c_en) set_cdb(tbl[i].c_idx, tbl[i].c_data, 0);
            cycle();
            chk($sformatf("tbl%0d_uen", i), 32'(bus.RoB_update_en), 32'(tbl[i].e_uen));
            chk($sformatf("tbl%0d_reg", i), 32'(bus.RoB_update_reg), 32'(tbl[i].e_reg));
            chk($sformatf("tbl%0d_idx", i), 32'(bus.RoB_update_index), 32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_data", i), bus.RoB_update_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
        end

        // Fill to full, wrap, refused allocations.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle(); set_alloc(6'(i + 1), 0, 0, 32'h0); cycle();
            chk("fill_alloc_index", 32'(bus.alloc_index), 32'((i + 1) % 8));
        end
        chk("fill_full", 32'(bus.full), 1);
        idle(); set_alloc(6'd40, 0, 0, 32'h0); set_cdb(3'd0, 32'h5A, 0); cycle();
        chk("ninth_full", 32'(bus.full), 1);
        chk("ninth_alloc_index", 32'(bus.alloc_index), 0);
        idle(); set_alloc(6'd40, 0, 0, 32'h0); cycle();
        chk("freed_uen", 32'(bus.RoB_update_en), 1);
        chk("freed_data", bus.RoB_update_data, 32'h5A);
        chk("freed_reg", 32'(bus.RoB_update_reg), 1);
        chk("freed_full", 32'(bus.full), 0);
        chk("freed_empty", 32'(bus.empty), 0);
        chk("freed_alloc_index", 32'(bus.alloc_index), 0);
        idle(); set_alloc(6'd41, 0, 0, 32'h0); cycle();
        chk("refill_full", 32'(bus.full), 1);
        chk("refill_alloc_index", 32'(bus.alloc_index), 1);

        // Mispredicted branch at the head flushes younger ready entries.
        do_reset();
        idle(); set_alloc(6'b100000, 1, 0, 32'h1000); cycle();
        idle(); set_alloc(6'd5, 0, 0, 32'h0); cycle();
        idle(); set_cdb(3'd1, 32'h51, 0); cycle();
        idle(); set_cdb(3'd0, 32'h0, 1); cycle();
        chk("br_pre_uen", 32'(bus.RoB_update_en), 0);
        idle(); cycle();
        chk("br_flush", 32'(bus.flush_signal), 1);
        chk("br_redirect", bus.redirect_pc, 32'h1000);
        chk("br_uen", 32'(bus.RoB_update_en), 0);
        chk("br_empty", 32'(bus.empty), 1);
        chk("br_alloc_index", 32'(bus.alloc_index), 0);
        idle(); set_alloc(6'd6, 0, 0, 32'h0); set_cdb(3'd0, 32'h99, 0); cycle();
        chk("postflush_flush", 32'(bus.flush_signal), 0);
        chk("postflush_uen", 32'(bus.RoB_update_en), 0);
        chk("postflush_empty", 32'(bus.empty), 1);
        chk("postflush_alloc_index", 32'(bus.alloc_index), 0);
        idle(); set_alloc(6'd7, 0, 0, 32'h0); cycle();
        chk("postflush_alloc", 32'(bus.alloc_index), 1);

        // Commit pending across a three-cycle stall.
        do_reset();
        idle(); set_alloc(6'd9, 0, 0, 32'h0); cycle();
        idle(); set_alloc(6'd10, 0, 0, 32'h0); set_cdb(3'd0, 32'h77, 0); cycle();
        idle(); set_cdb(3'd1, 32'h88, 0); cycle();
        chk("stall_pre_uen", 32'(bus.RoB_update_en), 1);
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 0; set_alloc(6'd11, 0, 0, 32'h0); cycle();
            chk("stall_uen", 32'(bus.RoB_update_en), 1);
            chk("stall_reg", 32'(bus.RoB_update_reg), 9);
            chk("stall_data", bus.RoB_update_data, 32'h77);
            chk("stall_alloc_index", 32'(bus.alloc_index), 2);
        end
        rdy = 1;
        idle(); cycle();
        chk("resume_uen", 32'(bus.RoB_update_en), 1);
        chk("resume_reg", 32'(bus.RoB_update_reg), 10);
        chk("resume_index", 32'(bus.RoB_update_index), 1);
        chk("resume_data", bus.RoB_update_data, 32'h88);
        idle(); cycle();
        chk("resume_drop_uen", 32'(bus.RoB_update_en), 0);
        chk("resume_empty", 32'(bus.empty), 1);

        // CDB bypass on the query path, then reset with entries in flight.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(); set_alloc(6'(i + 10), 0, 0, 32'h0); cycle();
        end
        idle(); set_cdb(3'd0, 32'h55, 0); cycle();
        idle(); set_cdb(3'd4, 32'hABCD, 0); bus.query_idx1 = 3'd4; bus.query_idx2 = 3'd3;
        #1;
        chk("bypass_ready1", 32'(bus.query_ready1), 1);
        chk("bypass_data1", bus.query_data1, 32'hABCD);
        chk("unwritten_ready2", 32'(bus.query_ready2), 0);
        chk("unwritten_data2", bus.query_data2, 0);
        cycle();
        chk("inflight_uen", 32'(bus.RoB_update_en), 1);
        chk("inflight_reg", 32'(bus.RoB_update_reg), 10);
        idle(); bus.query_idx1 = 3'd4;
        #1;
        chk("stored_ready1", 32'(bus.query_ready1), 1);
        chk("stored_data1", bus.query_data1, 32'hABCD);
        do_reset();
        idle(); set_alloc(6'd50, 0, 0, 32'h0); cycle();
        chk("post_rst_alloc_index", 32'(bus.alloc_index), 1);
        idle(); set_cdb(3'd0, 32'h66, 0); cycle();
        idle(); cycle();
        chk("post_rst_commit_idx", 32'(bus.RoB_update_index), 0);
        chk("post_rst_commit_reg", 32'(bus.RoB_update_reg), 50);
        chk("post_rst_commit_data", bus.RoB_update_data, 32'h66);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                set_alloc(($urandom_range(0, 7) == 0) ? 6'b100000 : 6'($urandom_range(0, 31)),
                          ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), $urandom());
            if ($urandom_range(0, 1) == 1) begin
                if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
                    k = $urandom_range(0, mq.size() - 1);
                    e = mq[k];
                    set_cdb(3'(e.idx), $urandom(), ($urandom_range(0, 7) == 0) ? ~e.pred : e.pred);
                end else
                    set_cdb(3'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)));
            end
            bus.query_idx1 = 3'($urandom_range(0, 7));
            bus.query_idx2 = 3'($urandom_range(0, 7));
            cycle();
        end
        rdy = 1;
        idle();
        #1 check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
